// File: rtl/half_adder_pkg.sv
// Shared constants and lane result type for the half_adder slice.
package half_adder_pkg;

    localparam int HA_WIDTH = 1;
    localparam int HA_CNT_W = 8;

    typedef struct packed {
        logic sum;
        logic carry;
    } lane_res_t;

endpackage

// File: rtl/half_adder_if.sv
// Valid-qualified operand/result bundle for half_adder.
// carry_cnt exists only when HALF_ADDER_CARRY_CNT_EN is defined.
interface half_adder_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) ();
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             valid_o;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] carry;
`ifdef HALF_ADDER_CARRY_CNT_EN
    logic [CNT_W-1:0] carry_cnt;
`endif

    modport master (
        output valid, a, b,
`ifdef HALF_ADDER_CARRY_CNT_EN
        input  carry_cnt,
`endif
        input  valid_o, sum, carry
    );

    modport slave (
        input  valid, a, b,
`ifdef HALF_ADDER_CARRY_CNT_EN
        output carry_cnt,
`endif
        output valid_o, sum, carry
    );
endinterface

// File: rtl/half_adder_cell.sv
// One combinational half-adder lane.
module half_adder_cell (
    input  logic a_in,
    input  logic b_in,
    output logic sum_o,
    output logic carry_o
);
    assign sum_o   = a_in ^ b_in;
    assign carry_o = a_in & b_in;
endmodule

// File: rtl/half_adder.sv
// Registered multi-lane half adder, one cycle latency, no backpressure.
// Optional saturating carry-event counter under HALF_ADDER_CARRY_CNT_EN.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH = HA_WIDTH,
    parameter int CNT_W = HA_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             valid_o,
    output logic [WIDTH-1:0] sum_o,
`ifdef HALF_ADDER_CARRY_CNT_EN
    output logic [CNT_W-1:0] carry_cnt_o,
`endif
    output logic [WIDTH-1:0] carry_o
);

    lane_res_t [WIDTH-1:0] lane;
    logic      [WIDTH-1:0] lane_sum;
    logic      [WIDTH-1:0] lane_carry;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a_in    (a_in[i]),
            .b_in    (b_in[i]),
            .sum_o   (lane[i].sum),
            .carry_o (lane[i].carry)
        );
        assign lane_sum[i]   = lane[i].sum;
        assign lane_carry[i] = lane[i].carry;
    end

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] carry_q, carry_d;

    // Results hold while no valid operand arrives.
    always_comb begin
        valid_d = valid_in;
        sum_d   = sum_q;
        carry_d = carry_q;
        if (valid_in) begin
            sum_d   = lane_sum;
            carry_d = lane_carry;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            valid_q <= valid_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;

`ifdef HALF_ADDER_CARRY_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_in && (|lane_carry) && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end

    assign carry_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: WIDTH=1 and WIDTH=4 (CNT_W=2) instances.
// Counter checks are compiled only when HALF_ADDER_CARRY_CNT_EN is defined.
module tb_half_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    half_adder_if #(.WIDTH(1), .CNT_W(8)) if1 ();
    half_adder_if #(.WIDTH(4), .CNT_W(2)) if4 ();

    half_adder #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .valid_in    (if1.valid),
        .a_in        (if1.a),
        .b_in        (if1.b),
        .valid_o     (if1.valid_o),
        .sum_o       (if1.sum),
`ifdef HALF_ADDER_CARRY_CNT_EN
        .carry_cnt_o (if1.carry_cnt),
`endif
        .carry_o     (if1.carry)
    );

    half_adder #(.WIDTH(4), .CNT_W(2)) u4 (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .valid_in    (if4.valid),
        .a_in        (if4.a),
        .b_in        (if4.b),
        .valid_o     (if4.valid_o),
        .sum_o       (if4.sum),
`ifdef HALF_ADDER_CARRY_CNT_EN
        .carry_cnt_o (if4.carry_cnt),
`endif
        .carry_o     (if4.carry)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lane-wise arithmetic reference: each lane is a 1-bit add with 2-bit result.
    task automatic ref_lanes(input logic [3:0] a, input logic [3:0] b,
                             input int w, output logic [3:0] s,
                             output logic [3:0] c);
        s = '0;
        c = '0;
        for (int i = 0; i < w; i++) begin
            int t;
            t = int'(a[i]) + int'(b[i]);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
        end
    endtask

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic c;
    } vec_t;

    vec_t tbl[5];

    logic [3:0] m1_sum, m1_carry, m4_sum, m4_carry, ts, tc;
    logic       m1_valid, m4_valid;
    int         m4_cnt;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        if1.valid = 1'b0; if1.a = '0; if1.b = '0;
        if4.valid = 1'b0; if4.a = '0; if4.b = '0;
        step();
        step();
        chk("rst_valid1", 32'(if1.valid_o), 0);
        chk("rst_sum1",   32'(if1.sum), 0);
        chk("rst_carry1", 32'(if1.carry), 0);
        chk("rst_valid4", 32'(if4.valid_o), 0);
`ifdef HALF_ADDER_CARRY_CNT_EN
        chk("rst_cnt4", 32'(if4.carry_cnt), 0);
`endif
        rst_n = 1'b1;

        // Truth table, back-to-back valid.
        for (int i = 0; i < 5; i++) begin
            if1.valid = 1'b1;
            if1.a = tbl[i].a;
            if1.b = tbl[i].b;
            step();
            chk($sformatf("tt_valid[%0d]", i), 32'(if1.valid_o), 1);
            chk($sformatf("tt_sum[%0d]", i),   32'(if1.sum), 32'(tbl[i].s));
            chk($sformatf("tt_carry[%0d]", i), 32'(if1.carry), 32'(tbl[i].c));
        end

        // Hold when valid drops; inputs ignored.
        if1.valid = 1'b1; if1.a = 1'b1; if1.b = 1'b1;
        step();
        chk("hold_v1", 32'(if1.valid_o), 1);
        if1.valid = 1'b0; if1.a = 1'b0; if1.b = 1'b0;
        step();
        chk("hold_v0", 32'(if1.valid_o), 0);
        chk("hold_sum", 32'(if1.sum), 0);
        chk("hold_carry", 32'(if1.carry), 1);
        if1.a = 1'b1; if1.b = 1'b0;
        step();
        chk("hold_sum2", 32'(if1.sum), 0);
        chk("hold_carry2", 32'(if1.carry), 1);

        // Reset mid-stream drops in-flight and same-cycle valid.
        if1.valid = 1'b1; if1.a = 1'b1; if1.b = 1'b1;
        step();
        chk("mid_v", 32'(if1.valid_o), 1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_v", 32'(if1.valid_o), 0);
        chk("mid_rst_s", 32'(if1.sum), 0);
        chk("mid_rst_c", 32'(if1.carry), 0);
        rst_n = 1'b1;
        if1.valid = 1'b0;
        step();
        chk("post_rst_v", 32'(if1.valid_o), 0);
        chk("post_rst_c", 32'(if1.carry), 0);
        if1.valid = 1'b1; if1.a = 1'b1; if1.b = 1'b0;
        step();
        chk("first_after_rst_v", 32'(if1.valid_o), 1);
        chk("first_after_rst_s", 32'(if1.sum), 1);
        if1.valid = 1'b0;

        // Lane independence.
        if4.valid = 1'b1; if4.a = 4'b1100; if4.b = 4'b1010;
        step();
        chk("w4_sum", 32'(if4.sum), 32'h6);
        chk("w4_carry", 32'(if4.carry), 32'h8);
        if4.valid = 1'b0;

`ifdef HALF_ADDER_CARRY_CNT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            int e;
            e = (i + 1 > 3) ? 3 : i + 1;
            if4.valid = 1'b1; if4.a = 4'b0001; if4.b = 4'b0001;
            step();
            chk($sformatf("cnt_sat[%0d]", i), 32'(if4.carry_cnt), 32'(e));
        end
        rst_n = 1'b0;
        if4.valid = 1'b0;
        step();
        rst_n = 1'b1;
        if4.valid = 1'b1; if4.a = 4'b0001; if4.b = 4'b0001;
        step();
        chk("cnt_one", 32'(if4.carry_cnt), 1);
        if4.valid = 1'b0; if4.a = 4'hF; if4.b = 4'hF;
        step();
        chk("cnt_novalid", 32'(if4.carry_cnt), 1);
        if4.valid = 1'b1; if4.a = 4'b0101; if4.b = 4'b1010;
        step();
        chk("cnt_nocarry", 32'(if4.carry_cnt), 1);
`endif

        // Randomized run against the lane-arithmetic model.
        rst_n = 1'b0;
        if1.valid = 1'b0; if4.valid = 1'b0;
        step();
        rst_n = 1'b1;
        m1_valid = 0; m1_sum = 0; m1_carry = 0;
        m4_valid = 0; m4_sum = 0; m4_carry = 0; m4_cnt = 0;
        for (int n = 0; n < 300; n++) begin
            logic r;
            r = ($urandom_range(0, 19) != 0);
            rst_n = r;
            if1.valid = $urandom_range(0, 3) != 0;
            if1.a = 1'($urandom); if1.b = 1'($urandom);
            if4.valid = $urandom_range(0, 3) != 0;
            if4.a = 4'($urandom); if4.b = 4'($urandom);
            if (!r) begin
                m1_valid = 0; m1_sum = 0; m1_carry = 0;
                m4_valid = 0; m4_sum = 0; m4_carry = 0; m4_cnt = 0;
            end else begin
                m1_valid = if1.valid;
                if (if1.valid) begin
                    ref_lanes({3'b0, if1.a}, {3'b0, if1.b}, 1, ts, tc);
                    m1_sum = ts; m1_carry = tc;
                end
                m4_valid = if4.valid;
                if (if4.valid) begin
                    ref_lanes(if4.a, if4.b, 4, ts, tc);
                    m4_sum = ts; m4_carry = tc;
                    if (tc != 0 && m4_cnt < 3) m4_cnt++;
                end
            end
            step();
            chk("rnd_v1", 32'(if1.valid_o), 32'(m1_valid));
            chk("rnd_s1", 32'(if1.sum), 32'(m1_sum[0]));
            chk("rnd_c1", 32'(if1.carry), 32'(m1_carry[0]));
            chk("rnd_v4", 32'(if4.valid_o), 32'(m4_valid));
            chk("rnd_s4", 32'(if4.sum), 32'(m4_sum));
            chk("rnd_c4", 32'(if4.carry), 32'(m4_carry));
`ifdef HALF_ADDER_CARRY_CNT_EN
            chk("rnd_cnt4", 32'(if4.carry_cnt), 32'(m4_cnt));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/half_adder.md
HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1, giving the number of independent half-adder lanes.
REQ-002 The module SHALL have parameter CNT_W, default 8, giving the width of the carry-event counter.
REQ-003 The module SHALL have port clk_in, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n_in, input, 1 bit, a synchronous, active-low reset.
REQ-005 The module SHALL have port valid_in, input, 1 bit, which qualifies a_in and b_in.
REQ-006 The module SHALL have port a_in, input, WIDTH bits, the first addend per lane.
REQ-007 The module SHALL have port b_in, input, WIDTH bits, the second addend per lane.
REQ-008 The module SHALL have port valid_o, output, 1 bit, which qualifies sum_o and carry_o.
REQ-009 The module SHALL have port sum_o, output, WIDTH bits, the per-lane sum bit.
REQ-010 The module SHALL have port carry_o, output, WIDTH bits, the per-lane carry bit.
REQ-011 The module SHALL have port carry_cnt_o, output, CNT_W bits, present only when HALF_ADDER_CARRY_CNT_EN is defined.

Function
REQ-012 Each lane i SHALL compute sum = a_in[i] XOR b_in[i] and carry = a_in[i] AND b_in[i], with no carry propagation between lanes.
REQ-013 For WIDTH=1 the truth table SHALL be: 00 -> sum 0, carry 0; 10 -> 1,0; 01 -> 1,0; 11 -> 0,1.
REQ-014 Latency SHALL be exactly one clock: inputs sampled at edge N appear on sum_o, carry_o and valid_o after edge N.
REQ-015 valid_o SHALL equal valid_in delayed by one cycle.
REQ-016 When valid_in=0, sum_o and carry_o SHALL hold their previous values.
REQ-017 There SHALL be no backpressure: every valid input produces an output, and back-to-back valid inputs SHALL be accepted every cycle.
REQ-018 Inputs SHALL be treated as don't-care while valid_in=0 and SHALL NOT affect any state.

Reset
REQ-019 While rst_n_in=0 at a rising edge, valid_o, sum_o, carry_o and carry_cnt_o SHALL all become 0.
REQ-020 A valid_in asserted in the same cycle as reset SHALL be discarded.
REQ-021 Reset SHALL take priority over every other update, and reset mid-stream SHALL drop any in-flight result.
REQ-022 The first valid input after reset deassertion SHALL be processed normally.

Configuration
REQ-023 When HALF_ADDER_CARRY_CNT_EN is defined, carry_cnt_o SHALL increment by 1 on each accepted valid_in cycle in which any lane produces carry=1.
REQ-024 carry_cnt_o SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-025 carry_cnt_o SHALL clear only on reset.
REQ-026 When HALF_ADDER_CARRY_CNT_EN is undefined, the port and the counter logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-027 Package half_adder_pkg SHALL hold the default WIDTH and CNT_W constants and a lane result typedef {sum, carry}.
REQ-028 A combinational sub-module half_adder_cell (1-bit a, b -> sum, carry) SHALL be instantiated once per lane using generate.
REQ-029 The registers SHALL reside in the half_adder top level.

Verification
REQ-030 Reset, then with WIDTH=1 and valid_in=1 drive a_in/b_in = 00, 10, 01, 11, 00 on consecutive cycles -> after one cycle of latency, sum/carry SHALL be 0/0, 1/0, 1/0, 0/1, 0/0.
REQ-031 Drive 11 with valid_in=1, then 00 with valid_in=0 -> valid_o SHALL go 1 then 0, and sum_o/carry_o SHALL hold 0/1.
REQ-032 Drive valid 11, then assert rst_n_in=0 on the next edge -> all outputs SHALL be 0 after that edge, and no stale valid_o SHALL appear after reset releases.
REQ-033 With WIDTH=4, drive a=4'b1100 and b=4'b1010 -> sum_o SHALL be 4'b0110 and carry_o SHALL be 4'b1000.
REQ-034 With CNT_EN defined and CNT_W=2, apply 5 valid cycles of 11 -> carry_cnt_o SHALL read 1, 2, 3, 3, 3.
REQ-035 With CNT_EN defined, apply valid 11 with valid_in=0 -> carry_cnt_o SHALL be unchanged.
